// File: rtl/bd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bd_pkg
// Purpose  : Shared types and helpers for the bundled-data transmit bridge.
// Revision : 1.0 - initial release
// ============================================================================
package bd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        REQ  = 2'd2,
        REL  = 2'd3
    } bd_state_t;

    // One extra MSB lets full and empty be told apart without a separate count.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : STAGES-deep single-bit synchroniser, asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bd_tx_bridge.sv
`default_nettype none
// ============================================================================
// Module   : bd_tx_bridge
// Purpose  : Clocked valid/ready to 4-phase bundled-data transmitter with FIFO.
//            Optional per-phase handshake timeout: BD_TX_BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bd_tx_bridge
    import bd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             bd_req,
    output logic [WIDTH-1:0] bd_data,
    input  logic             bd_ack,
    output logic             busy
`ifdef BD_TX_BRIDGE_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (SYNC_STAGES < 2) || (TIMEOUT < 1)) begin : g_param_check
        $error("bd_tx_bridge: illegal parameter set");
    end

    bd_state_t        state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] bd_data_q, bd_data_d;
    logic             s_ready_q, s_ready_d;
    logic             bd_req_q, bd_req_d;
    logic             busy_q, busy_d;
    logic             ack_prev_q;
    logic             ack_s, ack_rise;
    logic             fifo_empty, full_d, push, pop;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bd_ack),
        .q     (ack_s)
    );

    // REQ only exits on a fresh ack edge, so an ack already high at launch is ignored.
    assign ack_rise   = ack_s & ~ack_prev_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign push       = s_valid & s_ready_q;

`ifdef BD_TX_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic          phase_expired;

    assign phase_expired = ((state_q == REQ) || (state_q == REL)) && (phase_cnt_q == CW'(TIMEOUT));
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = LOAD;
            LOAD:    state_d = REQ;
            REQ:     if (ack_rise) state_d = REL;
            REL:     if (!ack_s) state_d = fifo_empty ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
`ifdef BD_TX_BRIDGE_TIMEOUT_EN
        if (phase_expired) state_d = IDLE;
`endif
    end

    // Outputs are registered from the next state so bd_req is glitch-free.
    always_comb begin
        pop       = (state_d == LOAD);
        bd_req_d  = (state_d == REQ);
        bd_data_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : bd_data_q;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, pop};
        full_d    = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                    (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
        s_ready_d = !full_d;
        busy_d    = (wr_ptr_d != rd_ptr_d) || (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            bd_data_q  <= '0;
            s_ready_q  <= 1'b0;
            bd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            bd_data_q  <= bd_data_d;
            s_ready_q  <= s_ready_d;
            bd_req_q   <= bd_req_d;
            busy_q     <= busy_d;
            ack_prev_q <= ack_s;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

`ifdef BD_TX_BRIDGE_TIMEOUT_EN
    // Counter holds the number of cycles spent in the current REQ/REL phase.
    always_comb begin
        phase_cnt_d   = phase_cnt_q;
        timeout_err_d = timeout_err_q;
        if ((state_d == REQ) || (state_d == REL)) begin
            phase_cnt_d = (state_d != state_q) ? CW'(1) : phase_cnt_q + CW'(1);
            if (phase_cnt_d == CW'(TIMEOUT)) timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            phase_cnt_q   <= phase_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign s_ready = s_ready_q;
    assign bd_req  = bd_req_q;
    assign bd_data = bd_data_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: doc/bd_tx_bridge.md
Name: bd_tx_bridge

Overview:
- Clocked-to-asynchronous bridge that drives a 4-phase bundled-data channel.
- Accepts words on a clocked valid/ready interface, buffers them in a small FIFO, and launches each word as stable bd_data followed by a bd_req rising edge.
- bd_req feeds the matched delay element (async_lib delay line) downstream. That element delays req so it arrives after the data at the async consumer.
- bd_ack returns asynchronously and is synchronised internally.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flop stages on bd_ack; minimum 2.
- TIMEOUT, 1024, cycles allowed per handshake phase (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  FIFO not full.
- s_data  in  WIDTH  upstream word.
- bd_req  out  1  bundled-data request, registered output, glitch-free; to delay line input.
- bd_data  out  WIDTH  bundled data, registered, stable from LOAD until ack low observed.
- bd_ack  in  1  asynchronous acknowledge from consumer.
- busy  out  1  high when FIFO non-empty or state != IDLE.

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values while rst_n=0:
  - bd_req=0, bd_data=0, FIFO empty, s_ready=0, busy=0, state=IDLE, synchroniser flops=0.
  - s_ready goes to 1 on the first clock edge after reset release.
- Upstream transfer:
  - A word is written when s_valid & s_ready at a rising edge.
  - s_ready = !full, registered from FIFO count, no combinational path from s_valid.
  - Simultaneous push and pop when full: push is refused (s_ready already 0). Pop proceeds.
  - Push to an empty FIFO in IDLE is visible to the FSM on the next cycle.
- Pointers: log2(DEPTH)+1 bits, wrap naturally; full/empty derived from MSB compare.
- FSM states:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD: bd_data <= FIFO head; pop; bd_req stays 0. Next cycle go to REQ. This guarantees one full clock of data setup before the req edge.
  - REQ: bd_req=1; stay until ack_s=1 (synchronised ack), then go to REL.
  - REL: bd_req=0; stay until ack_s=0. Then go to LOAD if FIFO non-empty, otherwise IDLE. bd_data is held through REL.
- Latency: word pushed at edge N with empty FIFO and IDLE:
  - LOAD at N+1.
  - bd_req rises at N+2.
  - Minimum handshake period is 2+2*SYNC_STAGES+2 cycles.
- bd_ack high while in IDLE or LOAD (protocol violation):
  - Ignored in IDLE/LOAD.
  - REQ is not left until ack_s rises after req; the FSM does not skip REL.
- Reset asserted mid-handshake: outputs clear immediately. The consumer is responsible for returning ack to 0; after reset the FSM waits in IDLE.
- bd_data never changes while bd_req=1 or while in REL.

Optional Feature:
- Macro: BD_TX_BRIDGE_TIMEOUT_EN.
- With the macro defined:
  - Adds output timeout_err (1 bit, reset 0).
  - A per-phase counter clears on entry to REQ and REL and increments each cycle in those states.
  - Reaching TIMEOUT sets timeout_err (sticky until reset).
  - The FSM forces bd_req=0 and returns to IDLE. The word is dropped and not retried.
- Without the macro: no port, no counter, and the FSM waits indefinitely.

Decomposition:
- Shared package bd_pkg holds:
  - bd_state_t enum (IDLE, LOAD, REQ, REL).
  - Localparam helpers for pointer width (clog2).
- Natural sub-module: sync_ff (SYNC_STAGES-deep, async active-low reset, 1-bit). Instantiated once for bd_ack and reusable elsewhere in async_lib.
- FIFO stays inline.

Test Plan:
- Reset and single word: push 8'hA5 at cycle 10 → bd_data=8'hA5 at cycle 11, bd_req rises cycle 12. Ack model responds after 3 cycles → bd_req falls SYNC_STAGES+1 cycles after ack rise; busy=0 after ack low is synchronised.
- Burst fill: push 8'h01..8'h06 back-to-back with the ack model stalled → s_ready=0 after 4 accepted words plus 1 in LOAD. Release ack → words emerge in order 01..05; 06 accepted once space frees.
- Data stability checker: random ack delays 0–20 cycles over 500 words → bd_data never changes while bd_req=1 or in REL; zero mismatches against a scoreboard.
- Spurious ack: hold bd_ack=1 in IDLE, push 8'h3C → bd_req rises after LOAD. The FSM must not enter REL until ack drops and rises again.
- Reset mid-REQ: assert rst_n=0 while bd_req=1 → bd_req=0 and bd_data=0 the same cycle (async). FIFO empty after release.
- Timeout with BD_TX_BRIDGE_TIMEOUT_EN and TIMEOUT=16: never ack → timeout_err=1 at cycle 16 of REQ, bd_req=0 next cycle. The next queued word is launched normally.
